cpu_timer: RTL

Memory-mapped interval timer that generates the IRQ input consumed by the CPU control unit. Sits on the data-memory bus beside data RAM: software loads a reload value, enables counting, and receives a level interrupt on each overflow until it clears the status bit. It also provides a free-running cycle counter for software timing.

---
 rtl/cpu_bus_pkg.sv | 36 +++
 rtl/timer_prescaler.sv | 28 ++
 rtl/cpu_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared bus constants and register decode for the cpu timer peripheral
package cpu_bus_pkg;

    localparam logic [31:0] TIMER_BASE  = 32'h4000_0000;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_000C;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_SYSTICK
    } reg_sel_e;

    // Full-word compare; any address with nonzero low bits decodes to nothing.
    function automatic reg_sel_e decode(input logic [31:0] addr, input logic [31:0] base);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr == base + OFF_TH)           sel = SEL_TH;
            else if (addr == base + OFF_TL)      sel = SEL_TL;
            else if (addr == base + OFF_TCON)    sel = SEL_TCON;
            else if (addr == base + OFF_SYSTICK) sel = SEL_SYSTICK;
        end
        return sel;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divides the clock into one-cycle ticks while enabled
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt;

    // With PRESCALE=1 LAST is 0 and cnt never leaves 0, so tick follows en.
    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/cpu_timer.sv
// rtl/cpu_timer.sv - memory-mapped reload timer with level irq and free-running cycle counter
module cpu_timer
    import cpu_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    logic        en;
    logic        ie;
    logic        st;
    logic        tick;

    reg_sel_e sel;
    logic     wr_th;
    logic     wr_tl;
    logic     wr_tcon;
    logic     ovf;

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign sel     = decode(addr, BASE_ADDR);
    assign wr_th   = we && (sel == SEL_TH);
    assign wr_tl   = we && (sel == SEL_TL);
    assign wr_tcon = we && (sel == SEL_TCON);

    // A software TL write suppresses the overflow that a coincident tick would cause.
    assign ovf = tick && !wr_tl && (tl == 32'hFFFF_FFFF);

    always_comb begin
        rdata = '0;
        if (re) begin
            case (sel)
                SEL_TH:      rdata = th;
                SEL_TL:      rdata = tl;
                SEL_TCON:    rdata = {29'd0, st, ie, en};
                SEL_SYSTICK: rdata = systick;
                default:     rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th      <= '0;
            tl      <= '0;
            systick <= '0;
            en      <= 1'b0;
            ie      <= 1'b0;
            st      <= 1'b0;
            irq     <= 1'b0;
        end else begin
            systick <= systick + 32'd1;
            irq     <= ie && st;

            if (wr_th) begin
                th <= wdata;
            end

            if (wr_tl) begin
                tl <= wdata;
            end else if (tick) begin
                tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
            end

            if (wr_tcon) begin
                en <= wdata[TCON_EN];
                ie <= wdata[TCON_IE];
            end

            // Overflow set beats a same-cycle software clear so no interrupt is lost.
            if (ovf && ie) begin
                st <= 1'b1;
            end else if (wr_tcon && !wdata[TCON_ST]) begin
                st <= 1'b0;
            end
        end
    end

endmodule
